// File: rtl/exec_muldiv_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// opcode encodings, FSM state type and the default datapath width.
package exec_muldiv_unit_pkg;

   localparam int MD_DATA_WIDTH = 32;

   localparam logic [2:0] MD_NOP   = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling for the muldiv unit: operand magnitudes/signs at issue and
// conditional two's-complement fix-up of the raw result at commit.
module muldiv_signfix #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   input  logic                  is_signed,
   output logic [DATA_WIDTH-1:0] mag_a,
   output logic [DATA_WIDTH-1:0] mag_b,
   output logic                  sign_a,
   output logic                  sign_b,
   input  logic [DATA_WIDTH-1:0] raw_hi,
   input  logic [DATA_WIDTH-1:0] raw_lo,
   input  logic                  is_mul,
   input  logic                  neg_main,
   input  logic                  neg_rem,
   output logic [DATA_WIDTH-1:0] fix_hi,
   output logic [DATA_WIDTH-1:0] fix_lo
);

   logic [2*DATA_WIDTH-1:0] prod;
   logic [2*DATA_WIDTH-1:0] prod_fixed;

   always_comb begin
      sign_a = is_signed & op_a[DATA_WIDTH-1];
      sign_b = is_signed & op_b[DATA_WIDTH-1];
      mag_a  = sign_a ? -op_a : op_a;
      mag_b  = sign_b ? -op_b : op_b;
   end

   // A product is negated as one 64-bit value; quotient and remainder independently.
   always_comb begin
      prod       = {raw_hi, raw_lo};
      prod_fixed = neg_main ? -prod : prod;
      if (is_mul) begin
         fix_hi = prod_fixed[2*DATA_WIDTH-1:DATA_WIDTH];
         fix_lo = prod_fixed[DATA_WIDTH-1:0];
      end else begin
         fix_hi = neg_rem  ? -raw_hi : raw_hi;
         fix_lo = neg_main ? -raw_lo : raw_lo;
      end
   end

endmodule

// File: rtl/exec_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO; one shift-add or
// restoring-divide step per cycle, stalling upstream until commit.
module exec_muldiv_unit
   import exec_muldiv_unit_pkg::*;
#(
   parameter int DATA_WIDTH = MD_DATA_WIDTH,
   parameter int OP_WIDTH   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  start,
   input  logic [OP_WIDTH-1:0]   op,
   input  logic [DATA_WIDTH-1:0] rs_val,
   input  logic [DATA_WIDTH-1:0] rt_val,
   output logic                  stall_req,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   md_state_t state, next_state;

   logic [CW-1:0]         counter;
   logic [DATA_WIDTH-1:0] acc_hi, acc_lo, operand, rs_orig;
   logic                  is_mul_q, neg_main_q, neg_rem_q, div_zero_q;

   logic                  is_md_op, is_signed_op, is_mul_op, issue, commit;
   logic [DATA_WIDTH-1:0] mag_a, mag_b, step_hi, step_lo, fix_hi, fix_lo;
   logic                  sign_a, sign_b;
   logic [DATA_WIDTH:0]   add_sum, shifted, diff;

   always_comb begin
      is_md_op     = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
      is_signed_op = (op == MD_MULT) || (op == MD_DIV);
      is_mul_op    = (op == MD_MULT) || (op == MD_MULTU);
      issue        = (state == IDLE) && start && is_md_op && !flush;
      commit       = (state == BUSY) && (counter == LAST) && !flush;
   end

   muldiv_signfix #(.DATA_WIDTH(DATA_WIDTH)) u_signfix (
      .op_a      (rs_val),
      .op_b      (rt_val),
      .is_signed (is_signed_op),
      .mag_a     (mag_a),
      .mag_b     (mag_b),
      .sign_a    (sign_a),
      .sign_b    (sign_b),
      .raw_hi    (step_hi),
      .raw_lo    (step_lo),
      .is_mul    (is_mul_q),
      .neg_main  (neg_main_q),
      .neg_rem   (neg_rem_q),
      .fix_hi    (fix_hi),
      .fix_lo    (fix_lo)
   );

   // Multiply: acc_lo holds the shifting multiplier. Divide: acc_hi is the partial remainder.
   always_comb begin
      add_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand : '0)};
      shifted = {acc_hi, acc_lo[DATA_WIDTH-1]};
      diff    = shifted - {1'b0, operand};
      if (is_mul_q) begin
         step_hi = add_sum[DATA_WIDTH:1];
         step_lo = {add_sum[0], acc_lo[DATA_WIDTH-1:1]};
      end else if (!diff[DATA_WIDTH]) begin
         step_hi = diff[DATA_WIDTH-1:0];
         step_lo = {acc_lo[DATA_WIDTH-2:0], 1'b1};
      end else begin
         step_hi = shifted[DATA_WIDTH-1:0];
         step_lo = {acc_lo[DATA_WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      stall_req  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            stall_req = issue;
            if (issue) next_state = BUSY;
         end
         BUSY: begin
            busy      = 1'b1;
            stall_req = !flush;
            if (counter == LAST) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (flush) next_state = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter    <= '0;
         acc_hi     <= '0;
         acc_lo     <= '0;
         operand    <= '0;
         rs_orig    <= '0;
         is_mul_q   <= 1'b0;
         neg_main_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else if (issue) begin
         counter    <= '0;
         acc_hi     <= '0;
         acc_lo     <= is_mul_op ? mag_b : mag_a;
         operand    <= is_mul_op ? mag_a : mag_b;
         rs_orig    <= rs_val;
         is_mul_q   <= is_mul_op;
         neg_main_q <= sign_a ^ sign_b;
         neg_rem_q  <= sign_a;
         div_zero_q <= !is_mul_op && (rt_val == '0);
      end else if (flush) begin
         counter <= '0;
      end else if (state == BUSY) begin
         counter <= counter + 1'b1;
         acc_hi  <= step_hi;
         acc_lo  <= step_lo;
      end
   end

   // Divide-by-zero bypasses the computed result so HI keeps the original dividend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         hi <= div_zero_q ? rs_orig : fix_hi;
         lo <= div_zero_q ? '1 : fix_lo;
      end else if ((state == IDLE) && start && !flush) begin
         if (op == MD_MTHI) hi <= rs_val;
         if (op == MD_MTLO) lo <= rs_val;
      end
   end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed self-checking bench for exec_muldiv_unit: stall timing, signed and
// unsigned mul/div results, divide-by-zero, MTHI/MTLO, flush and async reset.
module tb_exec_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        stall_req, busy, done;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   exec_muldiv_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .start     (start),
      .op        (op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .stall_req (stall_req),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   // Holds the instruction in execute until done, counting stall cycles; returns in the DONE cycle.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int done_seen);
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      stalls = 0; done_seen = 0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (stall_req) stalls++;
         if (done) begin
            done_seen = 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic check_result(input string name, input int stalls, input int done_seen,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      n_tests++;
      if (done_seen !== 1) begin n_fail++; $display("[TB] FAIL %s done: got %0d want 1", name, done_seen); end
      n_tests++;
      if (stalls !== 33) begin n_fail++; $display("[TB] FAIL %s stalls: got %0d want 33", name, stalls); end
      n_tests++;
      if (hi !== exp_hi) begin n_fail++; $display("[TB] FAIL %s hi: got %h want %h", name, hi, exp_hi); end
      n_tests++;
      if (lo !== exp_lo) begin n_fail++; $display("[TB] FAIL %s lo: got %h want %h", name, lo, exp_lo); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
      #3;
      n_tests++;
      if ({hi, lo} !== 64'h0) begin n_fail++; $display("[TB] FAIL reset hilo: got %h want 0", {hi, lo}); end
      n_tests++;
      if ({stall_req, busy, done} !== 3'b000) begin
         n_fail++; $display("[TB] FAIL reset ctrl: got %b want 000", {stall_req, busy, done});
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_multu_max();
      int s, d;
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, s, d);
      check_result("multu_max", s, d, 32'hFFFFFFFE, 32'h00000001);
      @(negedge clk);
      #1;
      n_tests++;
      if ({busy, done} !== 2'b00) begin
         n_fail++; $display("[TB] FAIL no_reissue: got busy/done %b want 00", {busy, done});
      end
      start = 1'b0;
   endtask

   task automatic test_mult_signed();
      int s, d;
      run_op(3'd1, 32'hFFFFFFFD, 32'd7, s, d);
      check_result("mult_neg", s, d, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op(3'd1, 32'h80000000, 32'h80000000, s, d);
      check_result("mult_min", s, d, 32'h40000000, 32'h00000000);
   endtask

   task automatic test_div();
      int s, d;
      run_op(3'd3, 32'hFFFFFFF9, 32'd2, s, d);
      check_result("div_neg", s, d, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op(3'd4, 32'd7, 32'd0, s, d);
      check_result("divu_zero", s, d, 32'h00000007, 32'hFFFFFFFF);
      run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, s, d);
      check_result("div_ovf", s, d, 32'h00000000, 32'h80000000);
   endtask

   task automatic test_mthi_mtlo_flush();
      int pulses;
      @(negedge clk);
      start = 1'b1; op = 3'd5; rs_val = 32'h1234;
      #1;
      n_tests++;
      if (stall_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mthi stall: got %b want 0", stall_req); end
      @(negedge clk);
      n_tests++;
      if (hi !== 32'h1234) begin n_fail++; $display("[TB] FAIL mthi hi: got %h want 00001234", hi); end
      op = 3'd6; rs_val = 32'h5678;
      #1;
      n_tests++;
      if (stall_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mtlo stall: got %b want 0", stall_req); end
      @(negedge clk);
      n_tests++;
      if (lo !== 32'h5678) begin n_fail++; $display("[TB] FAIL mtlo lo: got %h want 00005678", lo); end
      op = 3'd4; rs_val = 32'd100; rt_val = 32'd7;
      repeat (11) @(negedge clk);
      flush = 1'b1;
      #1;
      n_tests++;
      if ({busy, stall_req} !== 2'b10) begin
         n_fail++; $display("[TB] FAIL flush comb: got busy/stall %b want 10", {busy, stall_req});
      end
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush idle: got busy %b want 0", busy); end
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      n_tests++;
      if (pulses !== 0) begin n_fail++; $display("[TB] FAIL flush done: got %0d pulses want 0", pulses); end
      n_tests++;
      if ({hi, lo} !== 64'h00001234_00005678) begin
         n_fail++; $display("[TB] FAIL flush hilo: got %h want 0000123400005678", {hi, lo});
      end
   endtask

   task automatic test_async_reset();
      int s, d;
      @(negedge clk);
      start = 1'b1; op = 3'd2; rs_val = 32'd3; rt_val = 32'd5;
      repeat (21) @(negedge clk);
      rst_n = 1'b0; start = 1'b0;
      #1;
      n_tests++;
      if ({hi, lo} !== 64'h0) begin n_fail++; $display("[TB] FAIL async hilo: got %h want 0", {hi, lo}); end
      n_tests++;
      if ({stall_req, busy} !== 2'b00) begin
         n_fail++; $display("[TB] FAIL async ctrl: got stall/busy %b want 00", {stall_req, busy});
      end
      @(negedge clk); rst_n = 1'b1;
      run_op(3'd2, 32'd3, 32'd5, s, d);
      check_result("multu_after_rst", s, d, 32'd0, 32'd15);
   endtask

   task automatic test_back_to_back();
      int s, d;
      run_op(3'd4, 32'd10, 32'd3, s, d);
      check_result("b2b_divu", s, d, 32'd1, 32'd3);
      run_op(3'd2, 32'd2, 32'd2, s, d);
      check_result("b2b_multu", s, d, 32'd0, 32'd4);
      @(negedge clk); start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_mult_signed();
      test_div();
      test_mthi_mtlo_flush();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_muldiv_unit.md
Name: exec_muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, fed directly by the decode-to-execute pipeline register (ALU op, rs value, rt value).
- Executes MIPS MULT/MULTU/DIV/DIVU over 32 iteration cycles and owns the architectural HI/LO registers.
- Also handles MTHI/MTLO.
- Raises a stall request that freezes the upstream pipeline registers until the result is committed.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.
- OP_WIDTH, 3, width of muldiv opcode.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  abort current operation (exception/redirect).
- start  in  1  valid muldiv-class instruction present in execute.
- op  in  OP_WIDTH  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- rs_val  in  DATA_WIDTH  operand A / dividend / MTHI-MTLO source.
- rt_val  in  DATA_WIDTH  operand B / divisor.
- stall_req  out  1  hold upstream pipeline registers.
- busy  out  1  state is BUSY.
- done  out  1  one-cycle pulse: result committed to HI/LO.
- hi  out  DATA_WIDTH  HI register.
- lo  out  DATA_WIDTH  LO register.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; hi=lo=0; counter=0; internal accumulators=0; done=0.
- States:
  - IDLE: if start and op in 1..4 -> BUSY. Latch |rs|, |rt|, sign flags (signed ops only), op, counter=0.
  - BUSY: one iteration per cycle; counter increments. When counter==DATA_WIDTH-1 -> DONE, writing sign-fixed result to hi/lo on that edge.
  - DONE: done=1; start/op ignored, because the held instruction is the one just completed. Next state IDLE unconditionally.
- stall_req (combinational) = (state==BUSY) or (state==IDLE and start and op in 1..4).
  - Exactly 33 stall cycles per mul/div: 1 issue + 32 BUSY.
  - Instruction leaves execute at the end of the DONE cycle.
- busy = (state==BUSY).
- MTHI/MTLO in IDLE with start: hi (or lo) <= rs_val at the next edge; no stall, no done.
- NOP/reserved: no effect.
- Multiply: shift-add on 32-bit magnitudes into a 64-bit product. For MULT, negate the 64-bit product if signA^signB. hi=product[63:32], lo=product[31:0].
- Divide: restoring division on magnitudes, one quotient bit per cycle.
  - For DIV: quotient negated if signA^signB; remainder negated if signA. lo=quotient, hi=remainder.
  - Divisor zero (DIV or DIVU): still 32 cycles; lo=all ones, hi=rs_val (original value).
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).
- Flush: in any state, the next edge goes to IDLE.
  - hi/lo unchanged, no done pulse.
  - stall_req drops combinationally the same cycle flush is high.
  - Flush takes priority over start and over completion.
- HI/LO are only ever written on the BUSY->DONE edge, by MTHI/MTLO, or by reset.

Decomposition:
- Shared package:
  - op encodings (MD_NOP..MD_MTLO);
  - state enum (IDLE, BUSY, DONE);
  - DATA_WIDTH default.
- One sub-module is natural: muldiv_signfix, combinational.
  - Computes magnitude and sign of an operand at issue.
  - Conditionally negates the 64-bit product or quotient/remainder at commit.
- The iteration datapath and FSM stay in exec_muldiv_unit.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF, start held while stall_req -> stall_req high exactly 33 cycles; done one cycle; hi=0xFFFFFFFE, lo=0x00000001; no reissue during DONE.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 -> hi=0x1234, lo=0x5678 after one cycle each; stall_req never high. Then DIVU 100/7 with flush at BUSY cycle 10 -> IDLE next edge; hi/lo stay 0x1234/0x5678; no done pulse.
- rst_n low at BUSY cycle 20 -> hi=lo=0 immediately (async); stall_req=0; busy=0. After release, MULTU 3*5 -> hi=0, lo=15.
- Back-to-back: DIVU 10/3 completes (lo=3, hi=1); next-cycle MULTU 2*2 starts from IDLE -> lo=4 after a further 33 stall cycles.
